// File: rtl/wi23_defs.sv
// Shared constants and types for the wi23 data-memory path.
// Holds DMEM geometry, the default burst cap and the arbiter enums.
package wi23_defs;

    localparam int DATA_WIDTH = 32;
    localparam int DMEM_DEPTH = 14;
    localparam int MAX_BURST  = 8;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_rr_pick2.sv
// Two-way round-robin pick: on a tie, the port that did not win last time wins.
module rr_pick2
    import wi23_defs::*;
(
    input  logic  i_req0,
    input  logic  i_req1,
    input  port_e i_last,
    output logic  o_pick0,
    output logic  o_pick1
);

    assign o_pick1 = i_req1 && (!i_req0 || (i_last == PORT0));
    assign o_pick0 = i_req0 && !o_pick1;

endmodule

// File: rtl/dmem_arb.sv
// DMEM arbiter between the processor (port 0) and loader/DMA (port 1).
// Port 1 can lock the memory for bursts of up to MAX_BURST beats while port 0 waits.
module dmem_arb
    import wi23_defs::*;
#(
    parameter int ADDR_WIDTH = wi23_defs::DMEM_DEPTH,
    parameter int DATA_WIDTH = wi23_defs::DATA_WIDTH,
    parameter int MAX_BURST  = wi23_defs::MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [3:0]            we0,
    input  logic [3:0]            we1,
    input  logic [31:0]           addr0,
    input  logic [31:0]           addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e       r_state, w_state_nxt;
    port_e            r_last_gnt, w_last_nxt;
    logic [CNT_W-1:0] r_burst_cnt, w_cnt_nxt;
    logic             r_rd_vld;
    port_e            r_owner;
    logic             w_rr0, w_rr1;
    logic             w_g0, w_g1;
    logic             w_gnt0, w_gnt1;
    logic             w_rd_issue;
    logic             w_unused;

    assign w_unused = ^{addr0[31:ADDR_WIDTH], addr1[31:ADDR_WIDTH]};

    rr_pick2 u_rr (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_last  (r_last_gnt),
        .o_pick0 (w_rr0),
        .o_pick1 (w_rr1)
    );

    always_comb begin
        w_g0        = 1'b0;
        w_g1        = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_burst_cnt;
        case (r_state)
            IDLE: begin
                w_g0 = w_rr0;
                w_g1 = w_rr1;
                if (w_rr1 && lock1) begin
                    w_state_nxt = LOCK1;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            LOCK1: begin
                if (!req1) begin
                    w_g0        = w_rr0;
                    w_g1        = w_rr1;
                    w_state_nxt = IDLE;
                end else if (r_burst_cnt < CNT_MAX) begin
                    w_g1        = 1'b1;
                    w_cnt_nxt   = r_burst_cnt + CNT_ONE;
                    w_state_nxt = lock1 ? LOCK1 : IDLE;
                end else if (req0) begin
                    // Starvation guard: port 0 gets one beat after a full burst.
                    w_g0        = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_g1        = 1'b1;
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = lock1 ? LOCK1 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt == IDLE) w_cnt_nxt = '0;
    end

    assign w_gnt0     = w_g0 && rst_n;
    assign w_gnt1     = w_g1 && rst_n;
    assign w_last_nxt = w_gnt0 ? PORT0 : (w_gnt1 ? PORT1 : r_last_gnt);
    assign w_rd_issue = (w_gnt0 && (we0 == 4'b0000)) || (w_gnt1 && (we1 == 4'b0000));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_gnt  <= PORT1;
            r_burst_cnt <= '0;
            r_rd_vld    <= 1'b0;
            r_owner     <= PORT0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_gnt  <= w_last_nxt;
            r_burst_cnt <= w_cnt_nxt;
            r_rd_vld    <= w_rd_issue;
            r_owner     <= w_gnt1 ? PORT1 : PORT0;
        end
    end

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    always_comb begin
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0[ADDR_WIDTH-1:0];
            mem_wdata = wdata0;
        end else if (w_gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1[ADDR_WIDTH-1:0];
            mem_wdata = wdata1;
        end
    end

    // Return data follows the registered owner, not whoever holds the grant now.
    assign rvalid0 = r_rd_vld && (r_owner == PORT0);
    assign rvalid1 = r_rd_vld && (r_owner == PORT1);
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a behavioural 1-cycle synchronous DMEM.
module tb_dmem_arb;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, lock1;
    logic [3:0]  we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] dmem [0:4095];
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    int total = 0;
    int bad   = 0;

    dmem_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) dmem[ld_addr] <= ld_data;
        else for (int b = 0; b < 4; b++)
            if (mem_we[b]) dmem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= dmem[mem_addr[13:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        we0 = 4'h0; we1 = 4'h0;
    endtask

    initial begin
        logic [3:0]  p2;
        logic [11:0] p3;
        p2 = 4'b0101;
        p3 = 12'b1110_1111_1111;

        rst_n = 1'b0; lock1 = 1'b0;
        req0 = 1'b1; we0 = 4'hF; addr0 = 32'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;
        ld_en = 1'b1; ld_addr = 12'd4; ld_data = 32'hDEADBEEF;
        tick();
        ld_en = 1'b0;
        chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
        chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
        chk("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
        chk("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single read from port 0
        req0 = 1'b1; we0 = 4'h0; addr0 = 32'h10;
        @(negedge clk);
        chk("rd0_gnt0", {31'b0, gnt0}, 32'd1);
        chk("rd0_gnt1", {31'b0, gnt1}, 32'd0);
        chk("rd0_addr", {18'b0, mem_addr}, 32'h10);
        chk("rd0_we", {28'b0, mem_we}, 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("rd0_rvalid0", {31'b0, rvalid0}, 32'd1);
        chk("rd0_rdata0", rdata0, 32'hDEADBEEF);
        chk("rd0_rvalid1", {31'b0, rvalid1}, 32'd0);
        tick();
        @(negedge clk);
        chk("rd0_rvalid0_drop", {31'b0, rvalid0}, 32'd0);
        chk("rd0_rdata0_zero", rdata0, 32'd0);
        tick();

        // port 1 write, leaves last grant on port 1
        req1 = 1'b1; we1 = 4'hF; addr1 = 32'h40; wdata1 = 32'h12345678;
        @(negedge clk);
        chk("wr1_gnt1", {31'b0, gnt1}, 32'd1);
        chk("wr1_we", {28'b0, mem_we}, 32'hF);
        chk("wr1_wdata", mem_wdata, 32'h12345678);
        tick(); idle();

        // alternating tie, reads on both ports
        for (int k = 0; k < 4; k++) begin
            req0 = 1'b1; we0 = 4'h0; addr0 = 32'h10;
            req1 = 1'b1; we1 = 4'h0; addr1 = 32'h40;
            @(negedge clk);
            chk($sformatf("alt_gnt0_%0d", k), {31'b0, gnt0}, {31'b0, p2[k]});
            chk($sformatf("alt_gnt1_%0d", k), {31'b0, gnt1}, {31'b0, !p2[k]});
            if (k > 0) begin
                chk($sformatf("alt_rv0_%0d", k), {31'b0, rvalid0}, {31'b0, p2[k-1]});
                chk($sformatf("alt_rd1_%0d", k), rdata1, p2[k-1] ? 32'd0 : 32'h12345678);
            end
            tick();
        end
        idle();
        @(negedge clk);
        chk("alt_last_rv1", {31'b0, rvalid1}, 32'd1);
        chk("alt_last_rd1", rdata1, 32'h12345678);
        tick();

        // port 0 write so the next tie favours port 1
        req0 = 1'b1; we0 = 4'hF; addr0 = 32'h80; wdata0 = 32'h0;
        @(negedge clk);
        chk("wr0_gnt0", {31'b0, gnt0}, 32'd1);
        tick(); idle();

        // locked burst against a waiting port 0
        for (int k = 0; k < 12; k++) begin
            req0 = 1'b1; we0 = 4'hF; addr0 = 32'h80; wdata0 = 32'hA5A5A5A5;
            req1 = 1'b1; we1 = 4'hF; addr1 = 32'hC0; wdata1 = 32'h5A5A5A5A;
            lock1 = 1'b1;
            @(negedge clk);
            chk($sformatf("lock_gnt1_%0d", k), {31'b0, gnt1}, {31'b0, p3[k]});
            chk($sformatf("lock_gnt0_%0d", k), {31'b0, gnt0}, {31'b0, !p3[k]});
            tick();
        end
        idle();
        @(negedge clk);
        chk("lock_rel_gnt", {30'b0, gnt1, gnt0}, 32'd0);
        chk("lock_rel_we", {28'b0, mem_we}, 32'd0);
        tick();

        // three-beat burst, port 0 arrives on beat 2
        req1 = 1'b1; we1 = 4'hF; addr1 = 32'h0; wdata1 = 32'h11; lock1 = 1'b1;
        @(negedge clk);
        chk("b3_gnt1_0", {31'b0, gnt1}, 32'd1);
        chk("b3_addr_0", {18'b0, mem_addr}, 32'h0);
        tick();
        req0 = 1'b1; we0 = 4'h0; addr0 = 32'h40;
        addr1 = 32'h4; wdata1 = 32'h22;
        @(negedge clk);
        chk("b3_gnt1_1", {31'b0, gnt1}, 32'd1);
        chk("b3_gnt0_1", {31'b0, gnt0}, 32'd0);
        chk("b3_addr_1", {18'b0, mem_addr}, 32'h4);
        tick();
        addr1 = 32'h8; wdata1 = 32'h33; lock1 = 1'b0;
        @(negedge clk);
        chk("b3_gnt1_2", {31'b0, gnt1}, 32'd1);
        chk("b3_gnt0_2", {31'b0, gnt0}, 32'd0);
        chk("b3_addr_2", {18'b0, mem_addr}, 32'h8);
        tick();
        req1 = 1'b0; we1 = 4'h0;
        @(negedge clk);
        chk("b3_gnt0_after", {31'b0, gnt0}, 32'd1);
        chk("b3_addr_after", {18'b0, mem_addr}, 32'h40);
        tick(); idle();
        @(negedge clk);
        chk("b3_rv0", {31'b0, rvalid0}, 32'd1);
        chk("b3_rd0", rdata0, 32'h12345678);
        tick();

        // byte-lane write from port 0
        req0 = 1'b1; we0 = 4'b0010; addr0 = 32'h21; wdata0 = 32'h0000AB00;
        @(negedge clk);
        chk("bw_gnt0", {31'b0, gnt0}, 32'd1);
        chk("bw_we", {28'b0, mem_we}, 32'h2);
        chk("bw_addr", {18'b0, mem_addr}, 32'h21);
        tick(); idle();
        @(negedge clk);
        chk("bw_no_rv0", {31'b0, rvalid0}, 32'd0);
        tick();

        // reset with a port-1 read in flight
        req1 = 1'b1; we1 = 4'h0; addr1 = 32'h10;
        @(negedge clk);
        chk("rr_gnt1", {31'b0, gnt1}, 32'd1);
        tick();
        rst_n = 1'b0;
        idle();
        req0 = 1'b1; we0 = 4'hF;
        #1;
        chk("rr_rv1_in_rst", {31'b0, rvalid1}, 32'd0);
        chk("rr_rd1_in_rst", rdata1, 32'd0);
        chk("rr_gnt_in_rst", {30'b0, gnt1, gnt0}, 32'd0);
        chk("rr_we_in_rst", {28'b0, mem_we}, 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rr_rv1_after", {31'b0, rvalid1}, 32'd0);
        tick();
        req0 = 1'b1; we0 = 4'h0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 4'h0; addr1 = 32'h10;
        @(negedge clk);
        chk("rr_tie_gnt0", {31'b0, gnt0}, 32'd1);
        chk("rr_tie_gnt1", {31'b0, gnt1}, 32'd0);
        tick();
        @(negedge clk);
        chk("rr_tie2_gnt1", {31'b0, gnt1}, 32'd1);
        chk("rr_tie2_rv0", {31'b0, rvalid0}, 32'd1);
        chk("rr_tie2_rd0", rdata0, 32'hDEADBEEF);
        tick(); idle();
        @(negedge clk);
        chk("rr_tie3_rv1", {31'b0, rvalid1}, 32'd1);
        chk("rr_tie3_rd1", rdata1, 32'hDEADBEEF);
        chk("rr_tie3_rv0", {31'b0, rvalid0}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14 (DMEM_DEPTH), DMEM byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked grants to port 1 while port 0 waits.
REQ-004 SHALL have port clk  input  1  system clock (50MHz); all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0 / req1  input  1  access request, processor (0) / loader-DMA (1).
REQ-007 SHALL have ports we0 / we1  input  4  byte-lane write enables; 4'b0000 means read.
REQ-008 SHALL have ports addr0 / addr1  input  32  byte address; only [ADDR_WIDTH-1:0] used.
REQ-009 SHALL have ports wdata0 / wdata1  input  DATA_WIDTH  lane-aligned write data.
REQ-010 SHALL have input lock1  1  port 1 requests burst ownership.
REQ-011 SHALL have outputs gnt0 / gnt1  1  access accepted this cycle.
REQ-012 SHALL have outputs rvalid0 / rvalid1  1  read data valid for that port.
REQ-013 SHALL have outputs rdata0 / rdata1  DATA_WIDTH  read data for that port.
REQ-014 SHALL have outputs mem_we (4), mem_addr (ADDR_WIDTH), mem_wdata (DATA_WIDTH), and input mem_rdata (DATA_WIDTH): single-port DMEM, 1-cycle synchronous read.

Function
REQ-015 SHALL assert at most one of gnt0/gnt1 per cycle; gnt is combinational from req, lock1, and state in the same cycle.
REQ-016 SHALL drive the granted port's we/addr/wdata onto mem_* in the grant cycle; mem_we SHALL be 0 when no grant.
REQ-017 SHALL assert rvalidN exactly one cycle after a read grant (we==0) to port N, with rdataN = mem_rdata; writes produce no rvalid.
REQ-018 SHALL route read data by a registered owner tag, not by the current-cycle grant.
REQ-019 SHALL drive rdata0/rdata1 to 0 when the corresponding rvalid is low.
REQ-020 FSM SHALL have states IDLE and LOCK1.
REQ-021 IDLE: single requester wins; if both request, the port != last_gnt wins; last_gnt updates on every grant.
REQ-022 IDLE->LOCK1 SHALL occur when port 1 is granted with lock1=1; burst_cnt then loads 1.
REQ-023 LOCK1 with req1=1 and burst_cnt<MAX_BURST: SHALL grant port 1, increment burst_cnt, and hold port 0 off.
REQ-024 LOCK1 with burst_cnt==MAX_BURST and req0=1: SHALL grant port 0, clear burst_cnt, set last_gnt=0, and go to IDLE.
REQ-025 LOCK1 with burst_cnt==MAX_BURST and req0=0: SHALL grant port 1 (if req1) and reload burst_cnt to 1.
REQ-026 In LOCK1, a port-1 grant with lock1=0 SHALL be the final locked beat; the next state SHALL be IDLE.
REQ-027 In LOCK1 with req1=0, the cycle SHALL be arbitrated by IDLE rules, and the state SHALL go to IDLE.
REQ-028 Requesters SHALL hold req/we/addr/wdata stable until gnt; the arbiter SHALL NOT latch request fields.
REQ-029 Read and write to the same address in consecutive cycles SHALL return DMEM's registered value; the arbiter SHALL add no bypass.

Reset
REQ-030 On rst_n low, the block SHALL set: state=IDLE, last_gnt=1 (port 0 wins first tie), burst_cnt=0, owner tag cleared, rvalid0=rvalid1=0.
REQ-031 While rst_n is low, gnt0=gnt1=0 and mem_we=0.
REQ-032 Reset mid-burst or with a read pending SHALL discard the pending rvalid; no late rvalid after deassertion.

Structure
REQ-033 MAX_BURST default, port-index enum, and FSM state typedef SHALL live in wi23_defs; DATA_WIDTH/DMEM_DEPTH SHALL be reused from wi23_defs.
REQ-034 A natural sub-module is rr_pick2 (2-way round-robin pick with last_gnt); the rest SHALL stay flat.

Verification
REQ-035 Reset then req0 read addr 0x10 with DMEM[0x10]=0xDEADBEEF -> gnt0 same cycle; rvalid0=1, rdata0=0xDEADBEEF next cycle; rvalid1=0.
REQ-036 req0 and req1 both asserted for 4 cycles, lock1=0 -> grants alternate 0,1,0,1.
REQ-037 lock1=1, req1 held, req0 held for 12 cycles, MAX_BURST=8 -> 8 gnt1, then 1 gnt0, then gnt1 resumes.
REQ-038 Port 1 locked burst of 3 writes (we=4'hF, addr 0x0,0x4,0x8, lock1 low on 3rd) -> IDLE after 3rd; a pending req0 is granted next cycle.
REQ-039 Byte write we0=4'b0010, addr 0x21 -> mem_we=4'b0010 and mem_addr=0x21 in the grant cycle; no rvalid0.
REQ-040 rst_n asserted the cycle after a port-1 read grant -> rvalid1 never asserts; after release, the first tie goes to port 0.
